// File: rtl/uart_word_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_stream_bridge
// Brief   : Packs UART bytes into DUT input words and unpacks DUT result words
//           into UART bytes; traffic counters are viewable on the debug LEDs.
// Rev     : 1.0 - initial release
// ============================================================================
module uart_word_stream_bridge #(
    parameter int INPUT_WORD_BYTES  = 4,
    parameter int OUTPUT_WORD_BYTES = 4,
    parameter int LSB_FIRST         = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     received_data,
    input  logic                           received_valid,
    output logic                           received_ready,
    output logic [7:0]                     transmitting_data,
    output logic                           transmitting_valid,
    input  logic                           transmitting_ready,
    output logic [8*INPUT_WORD_BYTES-1:0]  dut_input_data,
    output logic                           dut_input_valid,
    input  logic                           dut_input_ready,
    input  logic [8*OUTPUT_WORD_BYTES-1:0] dut_output_data,
    input  logic                           dut_output_valid,
    output logic                           dut_output_ready,
    input  logic                           display_next_debug_value_button,
    output logic [7:0]                     debug_leds
);

    localparam int c_in_idx_w  = (INPUT_WORD_BYTES  > 1) ? $clog2(INPUT_WORD_BYTES)  : 1;
    localparam int c_out_idx_w = (OUTPUT_WORD_BYTES > 1) ? $clog2(OUTPUT_WORD_BYTES) : 1;
    localparam logic [c_in_idx_w-1:0]  c_in_last  = c_in_idx_w'(INPUT_WORD_BYTES - 1);
    localparam logic [c_out_idx_w-1:0] c_out_last = c_out_idx_w'(OUTPUT_WORD_BYTES - 1);

    typedef enum logic [0:0] {
        ASM_COLLECT = 1'b0,
        ASM_PRESENT = 1'b1
    } asm_state_t;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    asm_state_t                     r_asm_state;
    logic [c_in_idx_w-1:0]          r_in_idx;
    logic [8*INPUT_WORD_BYTES-1:0]  r_in_word;
    logic                           r_rx_ready;
    logic                           r_in_valid;

    ser_state_t                     r_ser_state;
    logic [c_out_idx_w-1:0]         r_out_idx;
    logic [8*OUTPUT_WORD_BYTES-1:0] r_out_word;
    logic                           r_out_ready;
    logic                           r_tx_valid;

    logic [15:0]                    r_rx_bytes;
    logic [15:0]                    r_in_words;
    logic [15:0]                    r_out_words;
    logic [15:0]                    r_tx_bytes;

    logic                           r_btn_meta;
    logic                           r_btn_sync;
    logic                           r_btn_prev;
    logic [2:0]                     r_view;
    logic [7:0]                     r_leds;

    logic                           w_rx_hs;
    logic                           w_in_hs;
    logic                           w_out_hs;
    logic                           w_tx_hs;
    logic                           w_btn_edge;
    logic [c_in_idx_w-1:0]          w_in_slot;
    logic [c_out_idx_w-1:0]         w_out_slot;
    logic [7:0]                     w_tx_byte;

    assign w_rx_hs  = received_valid   && r_rx_ready;
    assign w_in_hs  = r_in_valid       && dut_input_ready;
    assign w_out_hs = dut_output_valid && r_out_ready;
    assign w_tx_hs  = r_tx_valid       && transmitting_ready;

    // Byte order is mirrored in both directions when LSB_FIRST is cleared.
    assign w_in_slot  = (LSB_FIRST != 0) ? r_in_idx  : (c_in_last  - r_in_idx);
    assign w_out_slot = (LSB_FIRST != 0) ? r_out_idx : (c_out_last - r_out_idx);

    // ------------------------------------------------------------------
    // Assembler: UART bytes -> DUT input word
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_asm_state <= ASM_COLLECT;
            r_in_idx    <= '0;
            r_in_word   <= '0;
            r_rx_ready  <= 1'b1;
            r_in_valid  <= 1'b0;
        end else begin
            case (r_asm_state)
                ASM_COLLECT: begin
                    if (w_rx_hs) begin
                        for (int s = 0; s < INPUT_WORD_BYTES; s++) begin
                            if (w_in_slot == c_in_idx_w'(s)) begin
                                r_in_word[s*8 +: 8] <= received_data;
                            end
                        end
                        if (r_in_idx == c_in_last) begin
                            r_in_idx    <= '0;
                            r_asm_state <= ASM_PRESENT;
                            r_rx_ready  <= 1'b0;
                            r_in_valid  <= 1'b1;
                        end else begin
                            r_in_idx <= r_in_idx + 1'b1;
                        end
                    end
                end
                ASM_PRESENT: begin
                    if (dut_input_ready) begin
                        r_asm_state <= ASM_COLLECT;
                        r_rx_ready  <= 1'b1;
                        r_in_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_asm_state <= ASM_COLLECT;
                    r_in_idx    <= '0;
                    r_rx_ready  <= 1'b1;
                    r_in_valid  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: DUT output word -> UART bytes
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ser_state <= SER_IDLE;
            r_out_idx   <= '0;
            r_out_word  <= '0;
            r_out_ready <= 1'b1;
            r_tx_valid  <= 1'b0;
        end else begin
            case (r_ser_state)
                SER_IDLE: begin
                    if (w_out_hs) begin
                        r_out_word  <= dut_output_data;
                        r_out_idx   <= '0;
                        r_ser_state <= SER_SEND;
                        r_out_ready <= 1'b0;
                        r_tx_valid  <= 1'b1;
                    end
                end
                SER_SEND: begin
                    if (transmitting_ready) begin
                        if (r_out_idx == c_out_last) begin
                            r_out_idx   <= '0;
                            r_ser_state <= SER_IDLE;
                            r_out_ready <= 1'b1;
                            r_tx_valid  <= 1'b0;
                        end else begin
                            r_out_idx <= r_out_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_ser_state <= SER_IDLE;
                    r_out_idx   <= '0;
                    r_out_ready <= 1'b1;
                    r_tx_valid  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_tx_byte = 8'h00;
        for (int s = 0; s < OUTPUT_WORD_BYTES; s++) begin
            if (w_out_slot == c_out_idx_w'(s)) begin
                w_tx_byte = r_out_word[s*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Traffic counters (free-running, wrap at 16 bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_bytes  <= '0;
            r_in_words  <= '0;
            r_out_words <= '0;
            r_tx_bytes  <= '0;
        end else begin
            if (w_rx_hs)  r_rx_bytes  <= r_rx_bytes  + 16'd1;
            if (w_in_hs)  r_in_words  <= r_in_words  + 16'd1;
            if (w_out_hs) r_out_words <= r_out_words + 16'd1;
            if (w_tx_hs)  r_tx_bytes  <= r_tx_bytes  + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Debug view selection and LED register
    // ------------------------------------------------------------------
    assign w_btn_edge = r_btn_sync && !r_btn_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
            r_view     <= 3'd0;
        end else begin
            r_btn_meta <= display_next_debug_value_button;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
            if (w_btn_edge) begin
                r_view <= r_view + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_leds <= 8'h00;
        end else begin
            case (r_view)
                3'd0:    r_leds <= r_in_words[7:0];
                3'd1:    r_leds <= r_in_words[15:8];
                3'd2:    r_leds <= r_out_words[7:0];
                3'd3:    r_leds <= r_out_words[15:8];
                3'd4:    r_leds <= r_rx_bytes[7:0];
                3'd5:    r_leds <= r_rx_bytes[15:8];
                3'd6:    r_leds <= r_tx_bytes[7:0];
                default: r_leds <= r_tx_bytes[15:8];
            endcase
        end
    end

    assign received_ready     = r_rx_ready;
    assign dut_input_data     = r_in_word;
    assign dut_input_valid    = r_in_valid;
    assign dut_output_ready   = r_out_ready;
    assign transmitting_valid = r_tx_valid;
    assign transmitting_data  = w_tx_byte;
    assign debug_leds         = r_leds;

endmodule
`default_nettype wire

// File: doc/uart_word_stream_bridge.md
Name: uart_word_stream_bridge

Overview:
- Parametrised successor to the UART test harness glue.
- Sits between the uart_controller byte streams and a DUT with word-wide valid/ready streams.
- Assembles received bytes into input words and serialises DUT output words back to bytes.
- Keeps traffic counters that are viewable on the 8 debug LEDs; a button steps through the views.

Parameters:
- INPUT_WORD_BYTES, 4: bytes per DUT input word (>=1).
- OUTPUT_WORD_BYTES, 4: bytes per DUT output word (>=1).
- LSB_FIRST, 1:
  - 1: first UART byte maps to bits [7:0].
  - 0: first UART byte maps to the most significant byte.
  - Applies to both directions.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- received_data  input  8  byte from UART receiver.
- received_valid  input  1  received byte valid.
- received_ready  output  1  bridge accepts received byte.
- transmitting_data  output  8  byte to UART transmitter.
- transmitting_valid  output  1  transmit byte valid.
- transmitting_ready  input  1  transmitter accepts byte.
- dut_input_data  output  8*INPUT_WORD_BYTES  assembled word to DUT.
- dut_input_valid  output  1  word valid.
- dut_input_ready  input  1  DUT accepts word.
- dut_output_data  input  8*OUTPUT_WORD_BYTES  result word from DUT.
- dut_output_valid  input  1  result valid.
- dut_output_ready  output  1  bridge accepts result.
- display_next_debug_value_button  input  1  asynchronous pushbutton.
- debug_leds  output  8  selected debug byte.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Assembler goes to COLLECT with byte index 0; serialiser goes to IDLE with byte index 0.
  - All four counters, the view index, the button synchroniser and the edge register clear to 0.
  - Outputs after reset: received_ready=1, dut_output_ready=1, dut_input_valid=0, transmitting_valid=0, debug_leds=0x00.
  - A partial word in either direction is discarded.
- Handshake rule: a transfer occurs on any edge where valid&&ready.
  - Data and valid must be held stable while valid && !ready.
- Assembler FSM:
  - COLLECT:
    - received_ready=1, dut_input_valid=0.
    - Each accepted byte is written into byte slot idx, or slot INPUT_WORD_BYTES-1-idx when LSB_FIRST=0, then idx increments.
    - On acceptance of the last byte (idx==INPUT_WORD_BYTES-1): idx returns to 0 and the FSM goes to PRESENT.
  - PRESENT:
    - dut_input_valid=1, received_ready=0, word held.
    - On dut_input_ready the FSM returns to COLLECT, with received_ready=1 the next cycle.
  - Latency: dut_input_valid rises on the cycle after the last-byte handshake.
- Serialiser FSM:
  - IDLE: dut_output_ready=1, transmitting_valid=0. On a DUT handshake the word is captured, idx=0, and the FSM goes to SEND.
  - SEND:
    - transmitting_valid=1, dut_output_ready=0.
    - transmitting_data = byte slot idx (LSB_FIRST=1) or slot OUTPUT_WORD_BYTES-1-idx (LSB_FIRST=0).
    - On transmitting_ready, idx increments.
    - On the last byte's handshake the FSM returns to IDLE.
  - Latency: the first byte is valid the cycle after the word handshake.
- Both FSMs are independent; simultaneous activity in both directions is legal.
- INPUT_WORD_BYTES=1 or OUTPUT_WORD_BYTES=1: the last-byte condition holds at idx 0.
- Counters: 16-bit each, wrap 0xFFFF->0x0000, increment on their handshake.
  - rx_bytes: received handshakes.
  - in_words: DUT input handshakes.
  - out_words: DUT output handshakes.
  - tx_bytes: transmit handshakes.
- Button:
  - Two-flop synchroniser, then rising-edge detect (sync==1 && previous==0).
  - Each edge increments a 3-bit view index, wrapping 7->0.
  - A button held through reset produces one advance shortly after reset deasserts.
- debug_leds is registered (1-cycle latency from counter/view change). Views:
  - 0 = in_words[7:0], 1 = in_words[15:8]
  - 2 = out_words[7:0], 3 = out_words[15:8]
  - 4 = rx_bytes[7:0], 5 = rx_bytes[15:8]
  - 6 = tx_bytes[7:0], 7 = tx_bytes[15:8]

Test Plan:
- Input assembly, defaults: bytes 0x11,0x22,0x33,0x44 with dut_input_ready=1.
  - dut_input_data=0x44332211, valid one cycle after the 0x44 handshake.
  - in_words=1, rx_bytes=4.
- Input backpressure: hold dut_input_ready=0 for 10 cycles after assembly.
  - received_ready=0 and the word stays stable.
  - After ready, exactly one word handshake occurs and received_ready=1 the next cycle.
- Output serialisation: dut_output_data=0xA1B2C3D4 with transmitting_ready toggling 1,0,1,0,...
  - Bytes emitted D4,C3,B2,A1 with data stable during stalls.
  - dut_output_ready=0 until the A1 handshake; tx_bytes=4.
- LSB_FIRST=0, INPUT_WORD_BYTES=2, OUTPUT_WORD_BYTES=3:
  - Input 0xAB,0xCD -> dut_input_data 0xABCD.
  - Output 0x123456 -> bytes 0x12,0x34,0x56.
- Debug views: after 300 received bytes, 75 words, press the button 4 times.
  - debug_leds = 0x2C (rx_bytes[7:0]=300 mod 256).
  - 4 more presses wrap to view 0: 0x4B.
- Reset mid-operation: assert reset after 2 of 4 input bytes and during SEND.
  - All counters and debug_leds are 0, received_ready=1, transmitting_valid=0.
  - The next 4 bytes 0x01..0x04 produce 0x04030201.
